// File: rtl/alu_4_bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_4_bit_pkg
// Purpose  : Opcode encodings, operand width default and opcode helpers for
//            the registered 4-bit signed ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_4_bit_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef logic [2:0] alu_op_t;

  // Bit 2 doubles as Binvert/carry-in, so SUB and SLT sit in the upper half.
  localparam alu_op_t OP_AND  = 3'b000;
  localparam alu_op_t OP_OR   = 3'b001;
  localparam alu_op_t OP_ADD  = 3'b010;
  localparam alu_op_t OP_NAND = 3'b011;
  localparam alu_op_t OP_NOR  = 3'b100;
  localparam alu_op_t OP_RSVD = 3'b101;
  localparam alu_op_t OP_SUB  = 3'b110;
  localparam alu_op_t OP_SLT  = 3'b111;

  function automatic logic is_arith(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_1bit_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_1bit_slice
// Purpose  : One bit of the ALU: logic ops, full adder with B inversion and
//            the SLT "less" pass-through. Set/overflow are used on the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module alu_1bit_slice
  import alu_4_bit_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       binvert,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       overflow
);

  logic w_b_eff;
  logic w_sum;

  assign w_b_eff  = b ^ binvert;
  assign w_sum    = a ^ w_b_eff ^ cin;
  assign cout     = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);
  assign set      = w_sum;
  // Only meaningful on the MSB: carry in versus carry out.
  assign overflow = cin ^ cout;

  // Logic ops use the raw B; only the adder sees the inverted operand.
  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = w_sum;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_RSVD: result = 1'b0;
      OP_SUB:  result = w_sum;
      OP_SLT:  result = less;
      default: result = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_4_bit.sv
`default_nettype none
// ============================================================================
// Module   : alu_4_bit
// Purpose  : Registered 4-bit signed ALU (AND/OR/NAND/NOR/ADD/SUB/SLT) with
//            Zero and signed Overflow flags, one cycle latency.
//            Define ALU_4_BIT_SLT_SIGNED_FIX_EN for an overflow-corrected SLT.
// Revision : 1.0 - initial release
// ============================================================================
module alu_4_bit
  import alu_4_bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Operation,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  logic [WIDTH-1:0] w_result;
  logic             w_msb_set;
  logic             w_msb_ovf;
  logic             w_slt_bit;
  logic             w_zero;
  logic             w_overflow;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic w_cin;
    logic w_res;

    if (i == 0) begin : g_cin_lsb
      assign w_cin = Operation[2];
    end else begin : g_cin_chain
      assign w_cin = g_slice[i-1].g_low.w_cout;
    end

    if (i == WIDTH - 1) begin : g_msb
      logic w_unused_cout;
      alu_1bit_slice u_slice (
        .a        (A[i]),
        .b        (B[i]),
        .binvert  (Operation[2]),
        .cin      (w_cin),
        .less     (1'b0),
        .op       (Operation),
        .result   (w_res),
        .cout     (w_unused_cout),
        .set      (w_msb_set),
        .overflow (w_msb_ovf)
      );
    end else begin : g_low
      logic w_cout;
      logic w_unused_set;
      logic w_unused_ovf;
      // The SLT set bit feeds the LSB only; upper bits read zero.
      alu_1bit_slice u_slice (
        .a        (A[i]),
        .b        (B[i]),
        .binvert  (Operation[2]),
        .cin      (w_cin),
        .less     ((i == 0) ? w_slt_bit : 1'b0),
        .op       (Operation),
        .result   (w_res),
        .cout     (w_cout),
        .set      (w_unused_set),
        .overflow (w_unused_ovf)
      );
    end

    assign w_result[i] = w_res;
  end

`ifdef ALU_4_BIT_SLT_SIGNED_FIX_EN
  assign w_slt_bit = w_msb_set ^ w_msb_ovf;
`else
  assign w_slt_bit = w_msb_set;
`endif

  assign w_zero     = ~|w_result;
  assign w_overflow = is_arith(Operation) & w_msb_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_zero     <= w_zero;
      r_overflow <= w_overflow;
    end
  end

  assign Result   = r_result;
  assign Zero     = r_zero;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_4_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_4_bit
// Purpose  : Scoreboard testbench for alu_4_bit: directed vectors, timing,
//            asynchronous reset and randomized back-to-back traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_4_bit;
  import alu_4_bit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Operation;
  logic [3:0] Result;
  logic       Zero;
  logic       Overflow;

  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       v;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic       z;
    logic       v;
  } vec_t;

  exp_t sb_q[$];
  exp_t last_exp;
  exp_t e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  alu_4_bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Drive operands and record what the next capture edge must produce.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] r, input logic z, input logic v);
    A = a; B = b; Operation = op;
    sb_q.push_back(exp_t'{res: r, z: z, v: v});
  endtask

  // Reference model built on integer arithmetic rather than a carry chain.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t m;
    int   sa, sb, full;
    m  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_AND:  m.res = a & b;
      OP_OR:   m.res = a | b;
      OP_NAND: m.res = ~(a & b);
      OP_NOR:  m.res = ~(a | b);
      OP_ADD: begin full = sa + sb; m.res = full[3:0]; m.v = (full > 7) || (full < -8); end
      OP_SUB: begin full = sa - sb; m.res = full[3:0]; m.v = (full > 7) || (full < -8); end
      OP_SLT: begin
        full = sa - sb;
        m.v  = (full > 7) || (full < -8);
`ifdef ALU_4_BIT_SLT_SIGNED_FIX_EN
        m.res = {3'b000, (sa < sb)};
`else
        m.res = {3'b000, full[3]};
`endif
      end
      default: m.res = 4'b0000;
    endcase
    m.z = (m.res == 4'b0000);
    return m;
  endfunction

  task automatic run_table(input string name, input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, tbl[i].z, tbl[i].v);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      last_exp = e;
      tests_run++;
      if ({Result, Zero, Overflow} !== e) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
                 name, i, Result, Zero, Overflow, e.res, e.z, e.v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 4'b0101; B = 4'b0011; Operation = OP_OR;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== {4'b0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: got R=%b Z=%b V=%b, expected R=0000 Z=1 V=0", Result, Zero, Overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_logic();
    vec_t t[$];
    t = '{'{4'b0111, 4'b0010, OP_AND,  4'b0010, 1'b0, 1'b0},
          '{4'b0101, 4'b0010, OP_OR,   4'b0111, 1'b0, 1'b0},
          '{4'b0101, 4'b0010, OP_NAND, 4'b1111, 1'b0, 1'b0},
          '{4'b1111, 4'b1111, OP_NAND, 4'b0000, 1'b1, 1'b0},
          '{4'b0000, 4'b0000, OP_NOR,  4'b1111, 1'b0, 1'b0},
          '{4'b1111, 4'b0000, OP_NOR,  4'b0000, 1'b1, 1'b0}};
    run_table("logic", t);
  endtask

  task automatic test_add();
    vec_t t[$];
    t = '{'{4'b0101, 4'b0001, OP_ADD, 4'b0110, 1'b0, 1'b0},
          '{4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1}};
    run_table("add", t);
  endtask

  task automatic test_sub();
    vec_t t[$];
    t = '{'{4'b0101, 4'b0001, OP_SUB, 4'b0100, 1'b0, 1'b0},
          '{4'b1111, 4'b0001, OP_SUB, 4'b1110, 1'b0, 1'b0},
          '{4'b1111, 4'b1000, OP_SUB, 4'b0111, 1'b0, 1'b0},
          '{4'b1110, 4'b0111, OP_SUB, 4'b0111, 1'b0, 1'b1}};
    run_table("sub", t);
  endtask

  task automatic test_slt();
    vec_t t[$];
    t = '{'{4'b0101, 4'b0001, OP_SLT, 4'b0000, 1'b1, 1'b0},
          '{4'b0001, 4'b0011, OP_SLT, 4'b0001, 1'b0, 1'b0},
          '{4'b1101, 4'b0110, OP_SLT, 4'b0000, 1'b1, 1'b1}};
`ifdef ALU_4_BIT_SLT_SIGNED_FIX_EN
    t[2] = '{4'b1101, 4'b0110, OP_SLT, 4'b0001, 1'b0, 1'b1};
`endif
    run_table("slt", t);
  endtask

  task automatic test_reserved();
    vec_t t[$];
    t = '{'{4'b0000, 4'b0000, OP_RSVD, 4'b0000, 1'b1, 1'b0},
          '{4'b1111, 4'b1111, OP_RSVD, 4'b0000, 1'b1, 1'b0},
          '{4'b0111, 4'b0001, OP_RSVD, 4'b0000, 1'b1, 1'b0},
          '{4'b1000, 4'b0111, OP_RSVD, 4'b0000, 1'b1, 1'b0}};
    run_table("reserved", t);
  endtask

  task automatic test_timing();
    @(negedge clk);
    A = 4'b0011; B = 4'b0011; Operation = OP_ADD;
    #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== last_exp) begin
      tests_failed++;
      $display("FAIL hold_before_edge: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, last_exp.res, last_exp.z, last_exp.v);
    end
    #2;
    drive(4'b0101, 4'b0001, OP_ADD, 4'b0110, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    last_exp = e;
    tests_run++;
    if ({Result, Zero, Overflow} !== e) begin
      tests_failed++;
      $display("FAIL capture_last_value: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, e.res, e.z, e.v);
    end
    #2;
    drive(4'b1111, 4'b1111, OP_NAND, 4'b0000, 1'b1, 1'b0);
    #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== last_exp) begin
      tests_failed++;
      $display("FAIL hold_after_change: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, last_exp.res, last_exp.z, last_exp.v);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    last_exp = e;
    tests_run++;
    if ({Result, Zero, Overflow} !== e) begin
      tests_failed++;
      $display("FAIL next_edge_capture: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, e.res, e.z, e.v);
    end
  endtask

  task automatic test_reset_async();
    @(negedge clk);
    drive(4'b0101, 4'b0010, OP_OR, 4'b0111, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    tests_run++;
    if ({Result, Zero, Overflow} !== e) begin
      tests_failed++;
      $display("FAIL pre_reset_op: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, e.res, e.z, e.v);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== {4'b0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_assert: got R=%b Z=%b V=%b, expected R=0000 Z=1 V=0", Result, Zero, Overflow);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== {4'b0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got R=%b Z=%b V=%b, expected R=0000 Z=1 V=0", Result, Zero, Overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1);
    #1;
    tests_run++;
    if ({Result, Zero, Overflow} !== {4'b0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL release_pre_edge: got R=%b Z=%b V=%b, expected R=0000 Z=1 V=0", Result, Zero, Overflow);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    last_exp = e;
    tests_run++;
    if ({Result, Zero, Overflow} !== e) begin
      tests_failed++;
      $display("FAIL first_after_release: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
               Result, Zero, Overflow, e.res, e.z, e.v);
    end
  endtask

  // New operands land 2 time units after each edge; each edge must reflect
  // the operands that were stable before it, one result per cycle.
  task automatic test_back_to_back();
    logic [3:0] a, b;
    logic [2:0] op;
    exp_t       m;
    int         n = 20;
    @(negedge clk);
    a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); op = 3'($urandom_range(0, 7));
    m = model(a, b, op);
    drive(a, b, op, m.res, m.z, m.v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      tests_run++;
      if ({Result, Zero, Overflow} !== e) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got R=%b Z=%b V=%b, expected R=%b Z=%b V=%b",
                 i, Result, Zero, Overflow, e.res, e.z, e.v);
      end
      #1;
      if (i < n - 1) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); op = 3'($urandom_range(0, 7));
        m = model(a, b, op);
        drive(a, b, op, m.res, m.z, m.v);
      end
    end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_logic();
    test_add();
    test_sub();
    test_slt();
    test_reserved();
    test_timing();
    test_reset_async();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
